ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL take parameter PC_WIDTH, default 32, as the fetch address width.
REQ-002 The block SHALL take parameter INSTR_WIDTH, default 32, as the instruction word width.
REQ-003 The block SHALL take parameter DEPTH, default 4, as the slot count; legal values are powers of two, 2 or greater. CW = clog2(DEPTH)+1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: discard all queued and in-flight fetches.
REQ-007 The block SHALL have port pc_in, input, PC_WIDTH: fetch address from the program counter.
REQ-008 The block SHALL have port pc_in_valid, input, 1 bit: pc_in is valid this cycle.
REQ-009 The block SHALL have port stall, output, 1 bit: back-pressure to the program counter.
REQ-010 The block SHALL have port imem_req_valid, output, 1 bit: memory fetch request.
REQ-011 The block SHALL have port imem_req_addr, output, PC_WIDTH: request address.
REQ-012 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-013 The block SHALL have port imem_rsp_valid, input, 1 bit: in-order response strobe.
REQ-014 The block SHALL have port imem_rsp_data, input, INSTR_WIDTH: response instruction.
REQ-015 The block SHALL have port instr_valid, output, 1 bit: head instruction available to decode.
REQ-016 The block SHALL have port instr, output, INSTR_WIDTH: head instruction.
REQ-017 The block SHALL have port instr_pc, output, PC_WIDTH: address of the head instruction.
REQ-018 The block SHALL have port instr_ready, input, 1 bit: decode consumes the head.
REQ-019 The block SHALL have port occupancy, output, CW: count of allocated slots.

Function
REQ-020 The block SHALL hold DEPTH slots of {pc, instr, filled}, managed by alloc, fill and read pointers that each wrap modulo DEPTH.
REQ-021 The block SHALL define stall = rst | flush | ((occupancy + discard_cnt) == DEPTH), where discard_cnt is an internal CW-bit counter.
REQ-022 The block SHALL drive imem_req_valid = pc_in_valid & ~stall, and imem_req_addr = pc_in, combinationally.
REQ-023 On accept (imem_req_valid & imem_req_ready), the block SHALL allocate the slot at the alloc pointer, store pc_in with filled=0, and advance the alloc pointer.
REQ-024 On imem_rsp_valid with discard_cnt == 0 and at least one allocated unfilled slot, the block SHALL write imem_rsp_data to the slot at the fill pointer, set filled, and advance the fill pointer.
REQ-025 On imem_rsp_valid with discard_cnt > 0, the block SHALL drop the response and decrement discard_cnt.
REQ-026 On imem_rsp_valid with no outstanding request, the block SHALL ignore the response.
REQ-027 The block SHALL drive instr_valid as (occupancy > 0) & head.filled; instr and instr_pc SHALL come from the head slot, all from registers.
REQ-028 On instr_valid & instr_ready, the block SHALL free the head slot and advance the read pointer.
REQ-029 Latency: a request accepted in cycle N with its response in cycle M > N SHALL produce instr_valid no earlier than cycle M+1; there is no rsp-to-instr bypass.
REQ-030 Accept, fill and pop in the same cycle SHALL all take effect, with occupancy += accept - pop.
REQ-031 On flush, all pointers and occupancy SHALL go to 0 next cycle, and no accept or pop SHALL occur that cycle.
REQ-032 On flush, the block SHALL set discard_cnt_next = discard_cnt + (allocated unfilled count) - imem_rsp_valid, saturating at 0.
REQ-033 Back-to-back flushes SHALL accumulate discard_cnt correctly, and discard_cnt SHALL never exceed DEPTH.
REQ-034 When instr_valid is 0, instr and instr_pc SHALL hold their last values; when instr_valid is 1, instr, instr_pc and instr_valid SHALL be stable until popped or flushed.

Reset
REQ-035 While rst is high, the block SHALL force stall=1 and imem_req_valid=0, and SHALL ignore imem_rsp_valid.
REQ-036 Reset SHALL clear all pointers, occupancy, discard_cnt and every filled bit, so that instr_valid=0, occupancy=0, instr=0 and instr_pc=0 on the cycle after rst.
REQ-037 Reset asserted mid-operation SHALL abandon in-flight requests; the memory is reset alongside the block.

Verification
REQ-038 Single fetch: pc_in=0x100 accepted in cycle 1, rsp 0x00000013 in cycle 3 -> instr_valid=1, instr=0x13, instr_pc=0x100 in cycle 4; pop -> occupancy=0.
REQ-039 Fill to full: instr_ready=0, responses returned, 4 accepts 0x0, 0x4, 0x8, 0xC -> stall=1 and occupancy=4; one pop -> stall=0 next cycle; order preserved.
REQ-040 Flush with 2 in flight: flush -> discard_cnt=2; the next 2 responses are dropped; new fetch 0x200 -> instr_pc=0x200 with its own data.
REQ-041 Simultaneous events: with occupancy=2 and head filled, accept + fill + pop in one cycle -> occupancy stays 2, and the next head is the second-oldest pc.
REQ-042 Pointer wrap: 10 sequential fetches with continuous instr_ready=1 and 1-cycle memory latency -> all 10 instr_pc values in order, with no stall after warm-up.
REQ-043 Reset mid-run: rst asserted with occupancy=3 -> next cycle instr_valid=0, occupancy=0, stall=1 while rst is high.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch queue between the PC and decode.
// Tracks in-order memory fetches and drops responses of flushed requests.
module ifetch_queue #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   pc_in_valid,
  output logic                   stall,
  output logic                   imem_req_valid,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_ready,
  output logic [CW-1:0]          occupancy
);

  logic [PC_WIDTH-1:0]    pc_q  [DEPTH];
  logic [INSTR_WIDTH-1:0] ins_q [DEPTH];
  logic [DEPTH-1:0]       filled;

  logic [AW-1:0] alloc_ptr;
  logic [AW-1:0] fill_ptr;
  logic [AW-1:0] rd_ptr;

  logic [CW-1:0] occ;
  logic [CW-1:0] pend;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] disc_flush;
  logic [CW:0]   load;
  logic [CW:0]   disc_sum;

  logic [INSTR_WIDTH-1:0] last_instr;
  logic [PC_WIDTH-1:0]    last_pc;

  logic accept;
  logic rsp;
  logic drop;
  logic fill;
  logic head_valid;
  logic pop;

  assign load  = {1'b0, occ} + {1'b0, discard_cnt};
  assign stall = rst | flush | (load == (CW+1)'(DEPTH));

  assign imem_req_valid = pc_in_valid & ~stall;
  assign imem_req_addr  = pc_in;

  assign accept = imem_req_valid & imem_req_ready;
  assign rsp    = imem_rsp_valid & ~rst;
  assign drop   = rsp & (discard_cnt != '0);
  assign fill   = rsp & (discard_cnt == '0) & (pend != '0);

  assign head_valid = (occ != '0) & filled[rd_ptr];
  assign pop        = head_valid & instr_ready & ~flush;

  assign instr_valid = head_valid;
  assign instr       = head_valid ? ins_q[rd_ptr] : last_instr;
  assign instr_pc    = head_valid ? pc_q[rd_ptr]  : last_pc;
  assign occupancy   = occ;

  // Unfilled requests at flush become responses to throw away;
  // a response arriving in the flush cycle retires one of them.
  always_comb begin
    disc_sum   = {1'b0, discard_cnt} + {1'b0, pend};
    disc_flush = disc_sum[CW-1:0];
    if (imem_rsp_valid && disc_sum != '0)
      disc_flush = disc_sum[CW-1:0] - CW'(1);
  end

  // Slot payload storage; needs no reset since filled gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (accept)
        pc_q[alloc_ptr] <= pc_in;
      if (fill)
        ins_q[fill_ptr] <= imem_rsp_data;
    end
  end

  // Pointer, counter and filled-bit control.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      pend        <= '0;
      discard_cnt <= '0;
      filled      <= '0;
    end else if (flush) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      pend        <= '0;
      discard_cnt <= disc_flush;
    end else begin
      if (accept) begin
        filled[alloc_ptr] <= 1'b0;
        alloc_ptr         <= alloc_ptr + AW'(1);
      end
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop)
        discard_cnt <= discard_cnt - CW'(1);
      occ  <= occ + CW'(accept) - CW'(pop);
      pend <= pend + CW'(accept) - CW'(fill);
    end
  end

  // Remember the last presented head so outputs hold while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_instr <= '0;
      last_pc    <= '0;
    end else if (head_valid) begin
      last_instr <= ins_q[rd_ptr];
      last_pc    <= pc_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue.
// Each task drives one scenario and checks hand-computed values.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc_in;
  logic        pc_in_valid;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;

  ifetch_queue dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .pc_in(pc_in),
    .pc_in_valid(pc_in_valid),
    .stall(stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic clr();
    flush          = 1'b0;
    pc_in_valid    = 1'b0;
    pc_in          = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] pc);
    pc_in = pc; pc_in_valid = 1'b1; imem_req_ready = 1'b1;
    tick(); clr();
  endtask

  task automatic respond(input logic [31:0] d);
    imem_rsp_valid = 1'b1; imem_rsp_data = d;
    tick(); clr();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr();
    pc_in_valid = 1'b1; pc_in = 32'h40;
    tick(); tick(); #1;
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL rst_stall got %b want 1", stall); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL rst_req got %b want 0", imem_req_valid); end
    rst = 1'b0; clr();
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL rst_iv got %b want 0", instr_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++;
      $display("FAIL rst_occ got %0d want 0", occupancy); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++;
      $display("FAIL rst_out got %h/%h want 0/0", instr, instr_pc); end
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL rst_rel got %b want 0", stall); end
  endtask

  task automatic test_single();
    pc_in = 32'h100; pc_in_valid = 1'b1; imem_req_ready = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++; $display("FAIL sgl_req got %b %h want 1 100",
                         imem_req_valid, imem_req_addr); end
    tick(); clr();
    checks++; if (occupancy !== 3'd1 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL sgl_alloc got %0d %b want 1 0", occupancy, instr_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h13; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL sgl_bypass got %b want 0", instr_valid); end
    tick(); clr();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h13
                  || instr_pc !== 32'h100) begin errors++;
      $display("FAIL sgl_head got %b %h %h want 1 13 100",
               instr_valid, instr, instr_pc); end
    instr_ready = 1'b1;
    tick(); clr();
    checks++; if (occupancy !== 3'd0 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL sgl_pop got %0d %b want 0 0", occupancy, instr_valid); end
    checks++; if (instr !== 32'h13 || instr_pc !== 32'h100) begin errors++;
      $display("FAIL sgl_hold got %h %h want 13 100", instr, instr_pc); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) fetch(32'(4 * i));
    pc_in_valid = 1'b1; pc_in = 32'h10; #1;
    checks++; if (stall !== 1'b1 || imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL full_stall got %b %b want 1 0", stall, imem_req_valid); end
    checks++; if (occupancy !== 3'd4) begin errors++;
      $display("FAIL full_occ got %0d want 4", occupancy); end
    clr();
    for (int i = 0; i < 4; i++) respond(32'hA0 + 32'(i));
    checks++; if (instr_pc !== 32'h0 || instr !== 32'hA0) begin errors++;
      $display("FAIL full_head got %h %h want 0 a0", instr_pc, instr); end
    instr_ready = 1'b1;
    tick(); clr();
    checks++; if (stall !== 1'b0 || occupancy !== 3'd3) begin errors++;
      $display("FAIL full_unstall got %b %0d want 0 3", stall, occupancy); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)
                    || instr !== 32'hA0 + 32'(i)) begin errors++;
        $display("FAIL full_order%0d got %b %h %h want 1 %h %h", i,
                 instr_valid, instr_pc, instr, 4 * i, 32'hA0 + 32'(i)); end
      instr_ready = 1'b1;
      tick(); clr();
    end
    checks++; if (occupancy !== 3'd0) begin errors++;
      $display("FAIL full_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    fetch(32'h300); fetch(32'h304);
    flush = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++;
      $display("FAIL fl_stall got %b want 1", stall); end
    tick(); clr();
    checks++; if (occupancy !== 3'd0 || dut.discard_cnt !== 3'd2) begin
      errors++; $display("FAIL fl_disc got %0d %0d want 0 2",
                         occupancy, dut.discard_cnt); end
    fetch(32'h200);
    respond(32'hDEAD0001);
    respond(32'hDEAD0002);
    checks++; if (instr_valid !== 1'b0 || dut.discard_cnt !== 3'd0) begin
      errors++; $display("FAIL fl_drop got %b %0d want 0 0",
                         instr_valid, dut.discard_cnt); end
    respond(32'h2222);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200
                  || instr !== 32'h2222) begin errors++;
      $display("FAIL fl_new got %b %h %h want 1 200 2222",
               instr_valid, instr_pc, instr); end
    instr_ready = 1'b1;
    tick(); clr();
  endtask

  task automatic test_back_to_back();
    fetch(32'h500); fetch(32'h504); fetch(32'h508);
    flush = 1'b1; tick(); clr();
    fetch(32'h600);
    flush = 1'b1; tick(); clr();
    checks++; if (dut.discard_cnt !== 3'd4 || stall !== 1'b1) begin errors++;
      $display("FAIL b2b_disc got %0d %b want 4 1", dut.discard_cnt, stall); end
    for (int i = 0; i < 4; i++) respond(32'hBAD0 + 32'(i));
    checks++; if (dut.discard_cnt !== 3'd0 || stall !== 1'b0) begin errors++;
      $display("FAIL b2b_clr got %0d %b want 0 0", dut.discard_cnt, stall); end
    respond(32'h5555);
    checks++; if (occupancy !== 3'd0 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_stray got %0d %b want 0 0", occupancy, instr_valid); end
  endtask

  task automatic test_simul();
    fetch(32'h400); fetch(32'h404);
    respond(32'hA1);
    pc_in = 32'h408; pc_in_valid = 1'b1; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hB1; instr_ready = 1'b1; #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400
                  || imem_req_valid !== 1'b1) begin errors++;
      $display("FAIL sim_pre got %b %h %b want 1 400 1",
               instr_valid, instr_pc, imem_req_valid); end
    tick(); clr();
    checks++; if (occupancy !== 3'd2 || instr_valid !== 1'b1
                  || instr_pc !== 32'h404 || instr !== 32'hB1) begin errors++;
      $display("FAIL sim_post got %0d %b %h %h want 2 1 404 b1",
               occupancy, instr_valid, instr_pc, instr); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hC1; instr_ready = 1'b1;
    tick(); clr();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h408
                  || instr !== 32'hC1) begin errors++;
      $display("FAIL sim_third got %b %h %h want 1 408 c1",
               instr_valid, instr_pc, instr); end
    instr_ready = 1'b1;
    tick(); clr();
    checks++; if (occupancy !== 3'd0) begin errors++;
      $display("FAIL sim_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_wrap();
    int rx = 0;
    for (int i = 0; i < 16; i++) begin
      pc_in_valid    = (i < 10);
      pc_in          = 32'h1000 + 32'(4 * i);
      imem_req_ready = 1'b1;
      imem_rsp_valid = (i >= 1 && i <= 10);
      imem_rsp_data  = 32'hC000 + 32'(i - 1);
      instr_ready    = 1'b1;
      #1;
      if (i < 10) begin
        checks++; if (stall !== 1'b0) begin errors++;
          $display("FAIL wrap_stall%0d got %b want 0", i, stall); end
      end
      if (instr_valid === 1'b1 && rx < 10) begin
        checks++; if (instr_pc !== 32'h1000 + 32'(4 * rx)
                      || instr !== 32'hC000 + 32'(rx)) begin errors++;
          $display("FAIL wrap_rx%0d got %h %h want %h %h", rx, instr_pc,
                   instr, 32'h1000 + 32'(4 * rx), 32'hC000 + 32'(rx)); end
        rx++;
      end
      tick();
    end
    clr();
    checks++; if (rx !== 10 || occupancy !== 3'd0) begin errors++;
      $display("FAIL wrap_count got %0d %0d want 10 0", rx, occupancy); end
  endtask

  task automatic test_reset_mid();
    fetch(32'h700); fetch(32'h704); fetch(32'h708);
    respond(32'h77);
    checks++; if (occupancy !== 3'd3 || instr_valid !== 1'b1) begin errors++;
      $display("FAIL rm_pre got %0d %b want 3 1", occupancy, instr_valid); end
    rst = 1'b1; pc_in_valid = 1'b1; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h88; #1;
    checks++; if (stall !== 1'b1 || imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL rm_stall got %b %b want 1 0", stall, imem_req_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0 || occupancy !== 3'd0
                  || stall !== 1'b1) begin errors++;
      $display("FAIL rm_state got %b %0d %b want 0 0 1",
               instr_valid, occupancy, stall); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++;
      $display("FAIL rm_out got %h %h want 0 0", instr, instr_pc); end
    rst = 1'b0; clr();
    tick();
    checks++; if (dut.discard_cnt !== 3'd0 || stall !== 1'b0
                  || instr_valid !== 1'b0) begin errors++;
      $display("FAIL rm_after got %0d %b %b want 0 0 0",
               dut.discard_cnt, stall, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_back_to_back();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
